shift_unit_pipe: RTL

- Parametrised, pipelined, multi-mode barrel shifter for the datapath ALU.
- Successor to the fixed 16-bit combinational left shifter.
- Supports logical left/right, arithmetic right and both rotates, at any power-of-two width.
- Registered log-level pipeline with valid/ready handshakes on input and output. Carries a tag plus carry/zero/illegal flags.

---
 rtl/shift_unit_pipe.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_unit_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready
// handshakes. Shift levels are spread in ascending order across STAGES registers.
module shift_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH):0]   in_shamt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LW    = $clog2(WIDTH);
  localparam int SW    = LW + 1;
  localparam int BASE  = LW / STAGES;
  localparam int EXTRA = LW % STAGES;
  localparam int LAST  = STAGES - 1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Earlier stages absorb the leftover level when LW does not divide evenly.
  function automatic logic level_in_stage(input int k, input int s);
    int lo;
    int hi;
    lo = s * BASE + ((s < EXTRA) ? s : EXTRA);
    hi = lo + BASE + ((s < EXTRA) ? 1 : 0);
    return (k >= lo) && (k < hi);
  endfunction

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op, input int k);
    logic [WIDTH-1:0] r;
    int               s;
    s = 1 << k;
    case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $signed(d) >>> s;
      OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
      OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
      default: r = d;
    endcase
    return r;
  endfunction

  // Carry for plain shifts comes from the original operand; rotates use the result.
  function automatic logic carry_calc(input logic [WIDTH-1:0] orig, input logic [SW-1:0] shamt,
                                      input logic [2:0] op, input logic [WIDTH-1:0] res);
    logic          c;
    int            n;
    logic [LW-1:0] up_idx;
    logic [LW-1:0] dn_idx;
    n      = int'(shamt);
    up_idx = LW'(WIDTH - n);
    dn_idx = LW'(n - 1);
    case (op)
      OP_SLL:  c = (n >= 1 && n <= WIDTH) ? orig[up_idx] : 1'b0;
      OP_SRL:  c = (n >= 1 && n <= WIDTH) ? orig[dn_idx] : 1'b0;
      OP_SRA:  c = (n == 0) ? 1'b0 : ((n <= WIDTH) ? orig[dn_idx] : orig[WIDTH-1]);
      OP_ROL:  c = (shamt[LW-1:0] != '0) ? res[0] : 1'b0;
      OP_ROR:  c = (shamt[LW-1:0] != '0) ? res[WIDTH-1] : 1'b0;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic             v_r     [STAGES];
  logic [WIDTH-1:0] data_r  [STAGES];
  logic [WIDTH-1:0] orig_r  [STAGES];
  logic [SW-1:0]    shamt_r [STAGES];
  logic [LW-1:0]    amt_r   [STAGES];
  logic [2:0]       op_r    [STAGES];
  logic             ill_r   [STAGES];
  logic [TAG_W-1:0] tag_r   [STAGES];
  logic             carry_r;
  logic             zero_r;

  logic             src_v     [STAGES];
  logic [WIDTH-1:0] src_data  [STAGES];
  logic [WIDTH-1:0] src_orig  [STAGES];
  logic [SW-1:0]    src_shamt [STAGES];
  logic [LW-1:0]    src_amt   [STAGES];
  logic [2:0]       src_op    [STAGES];
  logic             src_ill   [STAGES];
  logic [TAG_W-1:0] src_tag   [STAGES];
  logic [WIDTH-1:0] nxt_data  [STAGES];

  logic             advance_s;
  logic             big_s;
  logic             rot_s;
  logic             ill_s;
  logic [WIDTH-1:0] pre_data_s;
  logic [LW-1:0]    pre_amt_s;
  logic             carry_s;

  assign advance_s = !v_r[LAST] || out_ready;
  assign in_ready  = advance_s;

  // Resolve out-of-range amounts up front so the levels only see amounts < WIDTH.
  always_comb begin
    big_s = in_shamt[LW];
    rot_s = (in_op == OP_ROL) || (in_op == OP_ROR);
    ill_s = (in_op > OP_ROR);
    case (in_op)
      OP_SLL, OP_SRL: pre_data_s = big_s ? '0 : in_data;
      OP_SRA:         pre_data_s = big_s ? {WIDTH{in_data[WIDTH-1]}} : in_data;
      default:        pre_data_s = in_data;
    endcase
    if (ill_s || (big_s && !rot_s)) begin
      pre_amt_s = '0;
    end else begin
      pre_amt_s = in_shamt[LW-1:0];
    end
  end

  // Stage inputs: stage 0 from the port, the rest from the previous register.
  always_comb begin
    src_v[0]     = in_valid && in_ready;
    src_data[0]  = pre_data_s;
    src_orig[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_amt[0]   = pre_amt_s;
    src_op[0]    = in_op;
    src_ill[0]   = ill_s;
    src_tag[0]   = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      src_v[s]     = v_r[s-1];
      src_data[s]  = data_r[s-1];
      src_orig[s]  = orig_r[s-1];
      src_shamt[s] = shamt_r[s-1];
      src_amt[s]   = amt_r[s-1];
      src_op[s]    = op_r[s-1];
      src_ill[s]   = ill_r[s-1];
      src_tag[s]   = tag_r[s-1];
    end
  end

  // Apply each stage's share of the shift levels.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      nxt_data[s] = src_data[s];
      for (int k = 0; k < LW; k++) begin
        if (level_in_stage(k, s) && src_amt[s][k]) begin
          nxt_data[s] = shift_level(nxt_data[s], src_op[s], k);
        end else begin
          nxt_data[s] = nxt_data[s];
        end
      end
    end
    carry_s = carry_calc(src_orig[LAST], src_shamt[LAST], src_op[LAST], nxt_data[LAST]);
  end

  // Pipeline registers: whole pipe advances together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_r[s]     <= 1'b0;
        data_r[s]  <= '0;
        orig_r[s]  <= '0;
        shamt_r[s] <= '0;
        amt_r[s]   <= '0;
        op_r[s]    <= 3'd0;
        ill_r[s]   <= 1'b0;
        tag_r[s]   <= '0;
      end
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (advance_s) begin
      for (int s = 0; s < STAGES; s++) begin
        v_r[s]     <= src_v[s];
        data_r[s]  <= nxt_data[s];
        orig_r[s]  <= src_orig[s];
        shamt_r[s] <= src_shamt[s];
        amt_r[s]   <= src_amt[s];
        op_r[s]    <= src_op[s];
        ill_r[s]   <= src_ill[s];
        tag_r[s]   <= src_tag[s];
      end
      carry_r <= src_ill[LAST] ? 1'b0 : carry_s;
      zero_r  <= (nxt_data[LAST] == '0);
    end
  end

  assign out_valid   = v_r[LAST];
  assign out_data    = data_r[LAST];
  assign out_carry   = carry_r;
  assign out_zero    = zero_r;
  assign out_illegal = ill_r[LAST];
  assign out_tag     = tag_r[LAST];

endmodule
